// File: rtl/inst_fetch_bridge.sv
// Instruction-side fetch bridge: translates the fetch pc, runs one SRAM-like
// bus transaction at a time, holds the returned word for decode, and drops
// responses that belong to fetches killed by a flush (or ce going low).
module inst_fetch_bridge #(
    parameter logic [31:0] RESET_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        ce,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        stallreq_if,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_phys;
    logic        kill;

    // Only stall[0] concerns the fetch stage; the other bits belong to later stages.
    logic        stall_unused;
    assign stall_unused = ^stall[5:1];

    // ce low kills an in-flight fetch exactly like a flush.
    assign kill = flush | ~ce;

    // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) map to physical by clearing the top 3 bits.
    always_comb begin
        pc_phys = pc;
        if (pc[31:29] == 3'b100 || pc[31:29] == 3'b101) begin
            pc_phys = {3'b000, pc[28:0]};
        end
    end

    // State, bus address and fetched word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            inst_addr_q <= '0;
            inst_q      <= RESET_INST;
        end else begin
            state_q     <= state_d;
            inst_addr_q <= inst_addr_d;
            inst_q      <= inst_d;
        end
    end

    // Next-state logic; data_ok outside DATA/DROP is a protocol error and ignored.
    always_comb begin
        state_d     = state_q;
        inst_addr_d = inst_addr_q;
        inst_d      = inst_q;
        unique case (state_q)
            IDLE: begin
                if (ce && !flush) begin
                    inst_addr_d = pc_phys;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (inst_addr_ok) begin
                    state_d = kill ? DROP : DATA;
                end else if (kill) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (inst_data_ok) begin
                    if (kill) begin
                        state_d = IDLE;
                    end else begin
                        inst_d  = inst_rdata;
                        state_d = HOLD;
                    end
                end else if (kill) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (inst_data_ok) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (kill || !stall[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        inst_req    = (state_q == ADDR);
        inst_addr   = inst_addr_q;
        inst        = (state_q == HOLD) ? inst_q : RESET_INST;
        stallreq_if = ce && (state_q != HOLD);
    end

endmodule

// File: doc/inst_fetch_bridge.md
Name: inst_fetch_bridge

Overview:
- Instruction-side responder for the fetch stage.
- Accepts the fetch stage's pc/ce, translates the virtual pc, and issues an SRAM-like request (req/addr_ok/data_ok) to the instruction bus.
- Returns the fetched instruction to the decode stage, and raises a stall request toward the pipeline controller until the word is available.
- Drops responses belonging to fetches killed by a flush.

Parameters:
- RESET_INST, 32'h00000000, instruction word driven whenever no valid fetch is held (nop).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- pc  input  32  fetch address from the fetch stage.
- ce  input  1  fetch enable from the fetch stage; low means no fetch.
- stall  input  6  pipeline stall vector; stall[0] high means pc holds this cycle.
- flush  input  1  pipeline flush (exception); kills the current fetch.
- inst  output  32  instruction to decode; valid only in HOLD.
- stallreq_if  output  1  stall request to the pipeline controller.
- inst_req  output  1  bus request.
- inst_addr  output  32  bus physical address, registered.
- inst_addr_ok  input  1  bus accepted the address this cycle.
- inst_data_ok  input  1  bus read data valid this cycle.
- inst_rdata  input  32  bus read data.

Behaviour:
- Reset (async, rst=1): state=IDLE, inst_addr=0, latched inst=RESET_INST, inst_req=0. stallreq_if=0 because ce=0 during reset.
- Address translation, applied when latching inst_addr:
  - pc[31:29] = 3'b100 or 3'b101 → {3'b000, pc[28:0]}.
  - Any other pc → passed through unchanged.
- Outputs:
  - inst_req = (state==ADDR).
  - inst = latched data in HOLD, else RESET_INST.
  - stallreq_if = ce && (state != HOLD).
- IDLE:
  - ce && !flush → latch translated pc into inst_addr; go to ADDR.
  - Otherwise stay in IDLE.
- ADDR (inst_req=1; inst_addr held stable):
  - addr_ok && !flush → DATA.
  - addr_ok && flush → DROP.
  - !addr_ok && flush → IDLE. An unaccepted request may be withdrawn.
  - Otherwise stay in ADDR.
- DATA:
  - data_ok && !flush → latch inst_rdata; go to HOLD.
  - data_ok && flush → IDLE; data discarded.
  - !data_ok && flush → DROP.
- DROP: wait for data_ok, discard the data, go to IDLE. flush is ignored here.
- HOLD (stallreq_if=0):
  - flush → IDLE.
  - !stall[0] → IDLE. The pc advances on this edge and decode latches inst.
  - stall[0] (stall from another source) → stay in HOLD; inst held.
- ce low in ADDR, DATA or HOLD is treated exactly like flush. ce low in DROP has no effect.
- Only one outstanding bus transaction exists at any time.
- A data_ok arriving in IDLE, ADDR or HOLD is a bus protocol error and is ignored.
- Minimum fetch latency with zero-wait bus (addr_ok in ADDR, data_ok one cycle later): ce → HOLD in 3 edges.
- Asserting rst mid-transaction returns to IDLE immediately. A late data_ok after reset is ignored.

Test Plan:
- Boot fetch: rst deasserts, ce=1, pc=32'hbfc00000, addr_ok on the first ADDR cycle, data_ok=1 next cycle with rdata=32'h3c011234.
  → inst_addr=32'h1fc00000, inst_req high exactly 1 cycle.
  → HOLD with inst=32'h3c011234, stallreq_if low.
- Wait states: addr_ok delayed 3 cycles, data_ok delayed 4 cycles.
  → inst_req and inst_addr held stable throughout.
  → stallreq_if high until HOLD.
  → exactly one transaction.
- Flush in DATA: flush pulses while waiting; data_ok arrives 2 cycles later with 32'hdeadbeef.
  → DROP, inst never equals 32'hdeadbeef.
  → next fetch uses the new pc (32'hbfc00380 → addr 32'h1fc00380).
- Flush in ADDR without addr_ok → inst_req drops the next cycle, IDLE, no DROP.
- External stall: HOLD with stall[0]=1 for 5 cycles → inst held constant, no new inst_req; stall[0]=0 → IDLE, then next fetch.
- Pass-through mapping and async reset:
  - pc=32'h00400000 → inst_addr=32'h00400000.
  - rst asserted mid-DATA → outputs reset in the same cycle without a clock edge.
